pwm_multicanal: RTL and testbench

PWM_MULTICANAL -- requirements
Module: pwm_multicanal

---
 rtl/pwm_multicanal.sv | 120 ++++++++++++
 tb/tb_pwm_multicanal.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator with prescaler, edge/center alignment and shadowed duty registers.
// Latency: pwm_out and fin_periodo are registered, one clk after the counter value they reflect.
// Backpressure: none; duty writes are accepted every clk, invalid channels are dropped.
module pwm_multicanal #(
  parameter int R = 8,
  parameter int N = 4,
  parameter int P = 21,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [P-1:0]  presc,
  input  logic [R-1:0]  periodo,
  input  logic          modo,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [R-1:0]  wr_ciclo,
  output logic [N-1:0]  pwm_out,
  output logic          fin_periodo
);

  localparam logic [R-1:0] ONE_R = R'(1);
  localparam logic [P-1:0] ONE_P = P'(1);

  logic [P-1:0] cnt_p;
  logic [R-1:0] q;
  logic         dir;          // 0 = counting up, 1 = counting down
  logic [R-1:0] per_act;
  logic         modo_act;
  logic [R-1:0] shadow    [N];
  logic [R-1:0] ciclo_act [N];

  logic         tick;
  logic         bound;
  logic         wr_ok;
  logic [R-1:0] q_nxt;
  logic         dir_nxt;

  // Prescaler terminal count and write-channel range check
  always_comb begin
    tick  = (cnt_p == presc);
    wr_ok = wr_en && (32'(wr_ch) < N);
  end

  // Next counter value and direction for the active mode; boundary when next Q is zero
  always_comb begin
    q_nxt   = q;
    dir_nxt = dir;
    if (!modo_act) begin
      q_nxt   = (q >= per_act) ? '0 : q + ONE_R;
      dir_nxt = 1'b0;
    end else if (!dir) begin
      if (per_act == '0) begin
        q_nxt = '0;
      end else if (q >= per_act) begin
        q_nxt   = q - ONE_R;
        dir_nxt = 1'b1;
      end else begin
        q_nxt = q + ONE_R;
      end
    end else begin
      q_nxt = q - ONE_R;
    end
    if (q_nxt == '0) begin
      dir_nxt = 1'b0;
    end
    bound = tick && (q_nxt == '0);
  end

  // Shadow duty registers; written independently of run state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (wr_ok && (wr_ch == CW'(i))) shadow[i] <= wr_ciclo;
      end
    end
  end

  // Prescaler, counter, active-value loading and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p       <= '0;
      q           <= '0;
      dir         <= 1'b0;
      per_act     <= '0;
      modo_act    <= 1'b0;
      pwm_out     <= '0;
      fin_periodo <= 1'b0;
      for (int i = 0; i < N; i++) ciclo_act[i] <= '0;
    end else if (!en) begin
      // Idle: hold the count at zero and keep active values tracking their sources
      cnt_p       <= '0;
      q           <= '0;
      dir         <= 1'b0;
      per_act     <= periodo;
      modo_act    <= modo;
      pwm_out     <= '0;
      fin_periodo <= 1'b0;
      for (int i = 0; i < N; i++) ciclo_act[i] <= shadow[i];
    end else begin
      // A count above a freshly lowered presc wraps to zero without producing a tick
      cnt_p <= (cnt_p >= presc) ? '0 : cnt_p + ONE_P;
      if (tick) begin
        q   <= q_nxt;
        dir <= dir_nxt;
      end
      if (bound) begin
        per_act  <= periodo;
        modo_act <= modo;
        for (int i = 0; i < N; i++) ciclo_act[i] <= shadow[i];
      end
      fin_periodo <= bound;
      for (int i = 0; i < N; i++) pwm_out[i] <= (q < ciclo_act[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal (R=8, N=3, P=21) with an expected-output scoreboard.
// Each clk the expected pwm_out/fin_periodo pair is queued, then popped and compared after the edge.
// Expected values come from closed-form period/duty formulas for each scenario.
module tb_pwm_multicanal;

  logic        clk;
  logic        reset;
  logic        en;
  logic [20:0] presc;
  logic [7:0]  periodo;
  logic        modo;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [7:0]  wr_ciclo;
  logic [2:0]  pwm_out;
  logic        fin_periodo;

  typedef struct {
    logic [2:0] pwm;
    logic       fin;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cs[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  pwm_multicanal #(.R(8), .N(3), .P(21)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .presc      (presc),
    .periodo    (periodo),
    .modo       (modo),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_ciclo   (wr_ciclo),
    .pwm_out    (pwm_out),
    .fin_periodo(fin_periodo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expectation, advance one clk, then pop and compare away from the edge
  task automatic expect_cycle(input string tag, input logic [2:0] p, input logic f);
    exp_t e;
    e.pwm = p;
    e.fin = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " pwm"}, {5'b0, pwm_out}, {5'b0, e.pwm});
    chk({tag, " fin"}, {7'b0, fin_periodo}, {7'b0, e.fin});
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [7:0] val);
    wr_en    = 1'b1;
    wr_ch    = ch;
    wr_ciclo = val;
  endtask

  // Counter value after edge k in the prescaler scenario (presc 3, lowered to 1 before edge 42)
  function automatic int qp(input int k);
    if (k < 0) return 0;
    if (k <= 41) return ((k + 1) / 4) % 5;
    if (k <= 43) return 0;
    return ((k - 44) / 2 + 1) % 5;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    reset    = 1'b0;
    en       = 1'b0;
    presc    = '0;
    periodo  = '0;
    modo     = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_ciclo = '0;

    #3;
    chk("reset pwm", {5'b0, pwm_out}, 8'h00);
    chk("reset fin", {7'b0, fin_periodo}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Edge-aligned setup while idle: period 9, ch0 duty 3, ch2 duty 255
    periodo = 8'd9;
    write_duty(2'd0, 8'd3);
    expect_cycle("idle0", 3'b000, 1'b0);
    write_duty(2'd2, 8'd255);
    expect_cycle("idle1", 3'b000, 1'b0);
    wr_en = 1'b0;
    expect_cycle("idle2", 3'b000, 1'b0);
    en = 1'b1;

    // Edge run with mid-period write, boundary-coincident write and an out-of-range channel write
    for (int k = 0; k < 70; k++) begin
      wr_en = 1'b0;
      if (k == 33) write_duty(2'd0, 8'd7);
      if (k == 49) write_duty(2'd0, 8'd5);
      if (k == 52) write_duty(2'd3, 8'd1);
      d = (k < 40) ? 3 : ((k < 60) ? 7 : 5);
      expect_cycle($sformatf("edge k=%0d", k), {1'b1, 1'b0, ((k % 10) < d)}, (k % 10) == 9);
    end
    wr_en = 1'b0;

    // Disable, reconfigure for center mode: period 4, ch0 duty 0, ch1 duty 2
    en      = 1'b0;
    modo    = 1'b1;
    periodo = 8'd4;
    write_duty(2'd0, 8'd0);
    expect_cycle("dis0", 3'b000, 1'b0);
    write_duty(2'd1, 8'd2);
    expect_cycle("dis1", 3'b000, 1'b0);
    wr_en = 1'b0;
    expect_cycle("dis2", 3'b000, 1'b0);
    en = 1'b1;

    for (int k = 0; k < 24; k++) begin
      expect_cycle($sformatf("center k=%0d", k), {1'b1, (cs[k % 8] < 2), 1'b0}, (k % 8) == 7);
    end

    // Prescaler scenario: edge mode, period 4, presc 3, then presc lowered while count is 2
    en      = 1'b0;
    modo    = 1'b0;
    presc   = 21'd3;
    expect_cycle("dis3", 3'b000, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 42) presc = 21'd1;
      expect_cycle($sformatf("presc k=%0d", k), {1'b1, (qp(k - 1) < 2), 1'b0},
                   (qp(k) == 0) && (qp(k - 1) == 4));
    end

    // Asynchronous reset mid-period: outputs drop without a clock edge
    #2;
    reset = 1'b0;
    #1;
    chk("async reset pwm", {5'b0, pwm_out}, 8'h00);
    chk("async reset fin", {7'b0, fin_periodo}, 8'h00);
    #1;
    reset = 1'b1;

    // Restart after reset: duties cleared, per_act 0 makes the first tick a boundary
    for (int k = 0; k < 12; k++) begin
      expect_cycle($sformatf("restart k=%0d", k), 3'b000, (k == 1) || (k == 11));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
